// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered asynchronous serial transmitter.
// Configurable data, parity and stop bits; line idles high.

module uart_tx #(
  parameter int IN_CLK_FR  = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        word,
  input  logic                        word_valid,
  output logic                        word_ready,
  output logic                        PIN_TX,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CPB =
    (IN_CLK_FR + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW = $clog2(CPB);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam bit USE_PAR =
    (PARITY == 1) || (PARITY == 2);
  localparam bit ODD_PAR = (PARITY == 1);
  localparam int NSTOP = (STOP_BITS == 2) ? 2 : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_baud;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr;
  logic [AW:0]          r_rd;

  logic [AW:0]          w_level;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_tick;
  logic                 w_last_stop;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_par;
  logic                 w_line;

  assign w_level = r_wr - r_rd;
  assign w_full  = (w_level == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (w_level == '0);
  assign w_push  = word_valid & ~w_full;
  assign w_head  = r_mem[r_rd[AW-1:0]];
  assign w_par   = ODD_PAR ? ~^w_head : ^w_head;

  assign w_tick = (r_state != S_IDLE) &&
                  (r_baud == CW'(CPB - 1));

  assign w_last_stop = (r_state == S_STOP) &&
                       w_tick &&
                       (r_bit == BW'(NSTOP - 1));

  assign w_pop = ~w_empty &&
                 ((r_state == S_IDLE) || w_last_stop);

  assign word_ready = ~w_full;
  assign fifo_level = w_level;

  // Line level implied by the current frame state.
  always_comb begin
    w_line = 1'b1;
    unique case (r_state)
      S_IDLE:  w_line = 1'b1;
      S_START: w_line = 1'b0;
      S_DATA:  w_line = r_shreg[0];
      S_PAR:   w_line = r_par;
      S_STOP:  w_line = 1'b1;
      default: w_line = 1'b1;
    endcase
  end

  // Queue storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= word;
    end
  end

  // Queue pointers with an extra wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Frame sequencer with baud and bit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_tick) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shreg <= w_head;
            r_par   <= w_par;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_bit   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shreg <= r_shreg >> 1;
            if (r_bit == BW'(DATA_BITS - 1)) begin
              r_bit   <= '0;
              r_state <= USE_PAR ? S_PAR : S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (w_tick) begin
            r_bit   <= '0;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_last_stop) begin
              r_bit <= '0;
              if (w_pop) begin
                r_shreg <= w_head;
                r_par   <= w_par;
                r_state <= S_START;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered line and activity outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PIN_TX <= 1'b1;
      busy   <= 1'b0;
    end else begin
      PIN_TX <= w_line;
      busy   <= (r_state != S_IDLE) || ~w_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks for uart_tx.
// Three instances cover 8N1, even/2-stop and odd parity.

module tb_uart_tx;

  localparam int CPB = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] w0, w1, w2;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic       tx0, tx1, tx2;
  logic       b0, b1, b2;
  logic [2:0] l0, l1, l2;

  int checks = 0;
  int errors = 0;

  logic       mon_en = 1'b0;
  logic [7:0] rxq [$];
  logic [7:0] mon_d;

  uart_tx #(
    .IN_CLK_FR(100000000), .BAUD_RATE(1000000),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .word(w0),
    .word_valid(v0), .word_ready(r0),
    .PIN_TX(tx0), .busy(b0), .fifo_level(l0)
  );

  uart_tx #(
    .IN_CLK_FR(100000000), .BAUD_RATE(1000000),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
    .FIFO_DEPTH(4)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .word(w1),
    .word_valid(v1), .word_ready(r1),
    .PIN_TX(tx1), .busy(b1), .fifo_level(l1)
  );

  uart_tx #(
    .IN_CLK_FR(100000000), .BAUD_RATE(1000000),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
    .FIFO_DEPTH(4)
  ) dut_o (
    .clk(clk), .rst_n(rst_n), .word(w2),
    .word_valid(v2), .word_ready(r2),
    .PIN_TX(tx2), .busy(b2), .fifo_level(l2)
  );

  // Reference receiver on the 8N1 line, mid-bit sampling.
  always begin
    @(negedge clk);
    if (mon_en && tx0 === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        mon_d[k] = tx0;
      end
      repeat (CPB) @(negedge clk);
      rxq.push_back(mon_d);
    end
  end

  function automatic logic line(input int s);
    case (s)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      0:       return b0;
      1:       return b1;
      default: return b2;
    endcase
  endfunction

  task automatic drive(input int s, input logic [7:0] d,
                       input logic v);
    case (s)
      0:       begin w0 = d; v0 = v; end
      1:       begin w1 = d; v1 = v; end
      default: begin w2 = d; v2 = v; end
    endcase
  endtask

  // Samples n bit periods; val = first sample of each,
  // uni = 1 where all CPB samples of the period agree.
  task automatic capture(input int s, input int n,
                         output logic [31:0] val,
                         output logic [31:0] uni,
                         output logic lastb);
    logic first;
    logic ok;
    val = '0;
    uni = '0;
    lastb = 1'b0;
    for (int b = 0; b < n; b++) begin
      first = line(s);
      ok = 1'b1;
      for (int c = 1; c < CPB; c++) begin
        @(negedge clk);
        if (line(s) !== first) ok = 1'b0;
      end
      val[b] = first;
      uni[b] = ok;
      lastb = busy_of(s);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (tx0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_pin: got %b want 1", tx0);
    end
    checks++;
    if (b0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b want 0", b0);
    end
    checks++;
    if (r0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1", r0);
    end
    checks++;
    if (l0 !== 3'd0) begin
      errors++;
      $display("FAIL rst_level: got %0d want 0", l0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_frame;
    logic [31:0] v, u;
    logic lb;
    logic [9:0] exp;
    exp = {1'b1, 8'h55, 1'b0};
    @(negedge clk);
    drive(0, 8'h55, 1'b1);
    @(negedge clk);
    drive(0, 8'hFF, 1'b0);
    checks++;
    if (tx0 !== 1'b1 || l0 !== 3'd1) begin
      errors++;
      $display("FAIL frame_n0: pin %b lvl %0d want 1 1",
               tx0, l0);
    end
    @(negedge clk);
    checks++;
    if (tx0 !== 1'b1 || b0 !== 1'b1 || l0 !== 3'd0) begin
      errors++;
      $display("FAIL frame_n1: pin %b busy %b lvl %0d want 1 1 0",
               tx0, b0, l0);
    end
    @(negedge clk);
    capture(0, 10, v, u, lb);
    checks++;
    if (v[9:0] !== exp) begin
      errors++;
      $display("FAIL frame_bits: got %b want %b", v[9:0], exp);
    end
    checks++;
    if (u[9:0] !== 10'h3FF) begin
      errors++;
      $display("FAIL frame_width: got %b want all 1", u[9:0]);
    end
    checks++;
    if (lb !== 1'b1 || b0 !== 1'b0 || tx0 !== 1'b1) begin
      errors++;
      $display("FAIL frame_busy_end: b999 %b b1000 %b pin %b want 1 0 1",
               lb, b0, tx0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v, u;
    logic lb;
    logic [19:0] exp;
    exp = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
    rxq.delete();
    @(negedge clk);
    drive(0, 8'hA3, 1'b1);
    @(negedge clk);
    drive(0, 8'h0F, 1'b1);
    @(negedge clk);
    drive(0, 8'h00, 1'b0);
    @(negedge clk);
    capture(0, 20, v, u, lb);
    checks++;
    if (v[19:0] !== exp) begin
      errors++;
      $display("FAIL b2b_bits: got %b want %b", v[19:0], exp);
    end
    checks++;
    if (u[19:0] !== 20'hFFFFF) begin
      errors++;
      $display("FAIL b2b_width: got %b want all 1", u[19:0]);
    end
    checks++;
    if (rxq.size() != 2 || rxq[0] !== 8'hA3 ||
        rxq[1] !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_rx: got %p want A3 0F", rxq);
    end
  endtask

  task automatic test_fifo_full;
    int i;
    int cyc;
    logic seen;
    logic rdy;
    logic [7:0] wd [6];
    for (int k = 0; k < 6; k++) wd[k] = 8'(8'h11 * (k + 1));
    rxq.delete();
    i = 0;
    cyc = 0;
    seen = 1'b0;
    while (i < 6 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (i == 5 && !seen) begin
        seen = 1'b1;
        checks++;
        if (r0 !== 1'b0 || l0 !== 3'd4) begin
          errors++;
          $display("FAIL full_ready: rdy %b lvl %0d want 0 4",
                   r0, l0);
        end
      end
      drive(0, wd[i], 1'b1);
      rdy = r0;
      @(posedge clk);
      if (rdy) i++;
    end
    @(negedge clk);
    drive(0, 8'h00, 1'b0);
    checks++;
    if (i != 6) begin
      errors++;
      $display("FAIL full_accept: got %0d want 6", i);
    end
    cyc = 0;
    while ((b0 || l0 != 0) && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rxq.size() != 6 || rxq[0] !== 8'h11 ||
        rxq[1] !== 8'h22 || rxq[2] !== 8'h33 ||
        rxq[3] !== 8'h44 || rxq[4] !== 8'h55 ||
        rxq[5] !== 8'h66) begin
      errors++;
      $display("FAIL full_order: got %p want 11..66", rxq);
    end
  endtask

  task automatic test_parity;
    logic [31:0] v, u;
    logic lb;
    logic [11:0] exp_e;
    logic [10:0] exp_o;
    exp_e = {2'b11, 1'b1, 8'h07, 1'b0};
    exp_o = {1'b1, 1'b0, 8'h07, 1'b0};
    @(negedge clk);
    drive(1, 8'h07, 1'b1);
    @(negedge clk);
    drive(1, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (tx1 !== 1'b1) begin
      errors++;
      $display("FAIL even_n1: got %b want 1", tx1);
    end
    @(negedge clk);
    capture(1, 12, v, u, lb);
    checks++;
    if (v[11:0] !== exp_e || u[11:0] !== 12'hFFF) begin
      errors++;
      $display("FAIL even_bits: got %b/%b want %b/all 1",
               v[11:0], u[11:0], exp_e);
    end
    checks++;
    if (lb !== 1'b1 || b1 !== 1'b0) begin
      errors++;
      $display("FAIL even_stop2: busy %b %b want 1 0",
               lb, b1);
    end
    @(negedge clk);
    drive(2, 8'h07, 1'b1);
    @(negedge clk);
    drive(2, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    capture(2, 11, v, u, lb);
    checks++;
    if (v[10:0] !== exp_o || u[10:0] !== 11'h7FF) begin
      errors++;
      $display("FAIL odd_bits: got %b/%b want %b/all 1",
               v[10:0], u[10:0], exp_o);
    end
    checks++;
    if (lb !== 1'b1 || b2 !== 1'b0) begin
      errors++;
      $display("FAIL odd_stop1: busy %b %b want 1 0", lb, b2);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    @(negedge clk);
    drive(0, 8'h00, 1'b1);
    @(negedge clk);
    drive(0, 8'h11, 1'b1);
    @(negedge clk);
    drive(0, 8'h22, 1'b1);
    @(negedge clk);
    drive(0, 8'h00, 1'b0);
    repeat (450) @(negedge clk);
    checks++;
    if (tx0 !== 1'b0 || l0 !== 3'd2) begin
      errors++;
      $display("FAIL rmid_pre: pin %b lvl %0d want 0 2",
               tx0, l0);
    end
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx0 !== 1'b1 || l0 !== 3'd0 ||
        b0 !== 1'b0 || r0 !== 1'b1) begin
      errors++;
      $display("FAIL rmid_async: pin %b lvl %0d busy %b rdy %b want 1 0 0 1",
               tx0, l0, b0, r0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || b0 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rmid_idle: got %0d active cycles want 0",
               bad);
    end
    repeat (800) @(negedge clk);
    rxq.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_loopback;
    logic [7:0] lb [24];
    int i;
    int cyc;
    int bad;
    logic rdy;
    for (int k = 0; k < 24; k++) lb[k] = 8'($urandom);
    rxq.delete();
    i = 0;
    cyc = 0;
    while (i < 24 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      drive(0, lb[i], 1'b1);
      rdy = r0;
      @(posedge clk);
      if (rdy) i++;
    end
    @(negedge clk);
    drive(0, 8'h00, 1'b0);
    checks++;
    if (i != 24) begin
      errors++;
      $display("FAIL loop_accept: got %0d want 24", i);
    end
    cyc = 0;
    while ((b0 || l0 != 0) && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (5) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      if (k >= rxq.size() || rxq[k] !== lb[k]) bad++;
    end
    checks++;
    if (rxq.size() != 24 || bad != 0) begin
      errors++;
      $display("FAIL loop_data: got %0d bytes %0d bad want 24 0",
               rxq.size(), bad);
    end
  endtask

  initial begin
    w0 = '0; w1 = '0; w2 = '0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    test_reset;
    test_frame;
    test_back_to_back;
    test_fifo_full;
    test_parity;
    test_reset_mid;
    test_loopback;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
